hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- HI/LO architectural register pair for the MIPS core.
- Sits directly downstream of the EX-stage multiply/divide unit and consumes its 64-bit result and done pulse.
- Also handles MTHI/MTLO writes and carries pending HI/LO writes through the MEM and WB pipeline latches, committing them at the end of WB.
- Returns forwarded HI/LO data for MFHI/MFLO issued in EX, and raises the EX stall request while a MULT/DIV is outstanding.

Parameters:
- DATA_W, 32, width of HI, LO and operands.
- FWD_EN, 1, 1 = bypass pending MEM/WB writes to MFHI/MFLO; 0 = read architectural HI/LO only.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall_all  in  1  global pipeline stall; all latches hold.
- flush  in  1  exception flush; kills the MEM-stage pending write and the EX stall request.
- ex_funct  in  6  EX instruction funct field; upstream drives 0 for non-SPECIAL opcodes.
- ex_rs_data  in  DATA_W  rs operand, the source for MTHI/MTLO.
- md_done  in  1  mult/div result valid (one-cycle pulse).
- md_result  in  2*DATA_W  {HI, LO} from mult/div.
- md_stall_req  out  1  request stall of IF..EX while a mult/div is incomplete.
- ex_hilo_rdata  out  DATA_W  value for MFHI/MFLO in EX (forwarded); 0 for other functs.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.

Behaviour:
- Funct codes:
  - MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13.
  - MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B.
- EX write decode (combinational):
  - MULT/MULTU/DIV/DIVU: we_hi = we_lo = 1; data = md_result[63:32] / [31:0].
  - MTHI: we_hi = 1, hi data = ex_rs_data.
  - MTLO: we_lo = 1, lo data = ex_rs_data.
  - Otherwise no write.
- md_stall_req = (funct is MULT/MULTU/DIV/DIVU) && !md_done && !flush && !rst.
- Pipeline: EX→MEM latch and MEM→WB latch, each holding {we_hi, we_lo, hi_d, lo_d}.
- Advance only when !stall_all && !md_stall_req, in the same posedge:
  - arch HI/LO <= WB write, per-half enables;
  - WB <= MEM;
  - MEM <= EX.
- When stall_all or md_stall_req is high, all latches and arch HI/LO hold. WB commit happens only on an advancing edge, never repeated.
- A mult/div enters MEM only on the cycle md_done=1 and the pipe advances, so exactly one write per instruction.
- flush (synchronous, overrides stall_all):
  - MEM latch enables <= 0.
  - WB still commits its write and the WB latch <= 0.
  - The EX instruction is not latched.
- rst:
  - hi, lo, all latch enables and data <= 0.
  - md_stall_req deasserts combinationally while rst is high.
  - ex_hilo_rdata reflects the reset state on the next cycle.
- Forwarding (FWD_EN=1), per half independently:
  - Priority: MEM write > WB write > arch register.
  - MFHI selects the HI half, MFLO the LO half.
  - Latency 0: combinational from latch state.
- Writes to a single half never disturb the other half at any stage.
- Reset values: hi = 0, lo = 0, md_stall_req = 0, ex_hilo_rdata = 0.

Test Plan:
- MTHI 32'hDEAD_BEEF, then MFHI next cycle → ex_hilo_rdata = DEADBEEF via MEM forward; hi = DEADBEEF exactly 2 advancing edges after MTHI leaves EX; lo unchanged = 0.
- MULT with md_done delayed 3 cycles (md_result = 64'h1234_5678_9ABC_DEF0) → md_stall_req = 1 for 3 cycles, 0 on the done cycle; hi = 12345678, lo = 9ABCDEF0 after 2 more advancing edges.
- MTLO 32'h1 followed immediately by MTLO 32'h2, then MFLO → returns 2 (MEM beats WB); final lo = 2.
- MTHI 32'hAAAA in MEM with flush asserted → hi never becomes AAAA; a WB-stage MTLO 32'h5 in the same cycle still commits lo = 5.
- stall_all held 4 cycles with MTHI 32'h77 in WB → hi changes only on the first edge after stall_all drops; no double commit.
- rst pulse mid-DIV (md_stall_req = 1) → next cycle md_stall_req = 0, hi = lo = 0, all pending writes discarded.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with MEM/WB pending-write latches,
// MFHI/MFLO forwarding and the multiply/divide EX stall request.
module hilo_unit #(
  parameter int DATA_W = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_all,
  input  logic                flush,
  input  logic [5:0]          ex_funct,
  input  logic [DATA_W-1:0]   ex_rs_data,
  input  logic                md_done,
  input  logic [2*DATA_W-1:0] md_result,
  output logic                md_stall_req,
  output logic [DATA_W-1:0]   ex_hilo_rdata,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  logic              w_isMd;
  logic              w_exWeHi;
  logic              w_exWeLo;
  logic [DATA_W-1:0] w_exHiD;
  logic [DATA_W-1:0] w_exLoD;
  logic              w_advance;
  logic [DATA_W-1:0] w_fwdHi;
  logic [DATA_W-1:0] w_fwdLo;

  logic              r_memWeHi;
  logic              r_memWeLo;
  logic [DATA_W-1:0] r_memHiD;
  logic [DATA_W-1:0] r_memLoD;
  logic              r_wbWeHi;
  logic              r_wbWeLo;
  logic [DATA_W-1:0] r_wbHiD;
  logic [DATA_W-1:0] r_wbLoD;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_comb begin
    w_isMd   = (ex_funct == FN_MULT) || (ex_funct == FN_MULTU) ||
               (ex_funct == FN_DIV)  || (ex_funct == FN_DIVU);
    w_exWeHi = w_isMd || (ex_funct == FN_MTHI);
    w_exWeLo = w_isMd || (ex_funct == FN_MTLO);
    w_exHiD  = w_isMd ? md_result[2*DATA_W-1:DATA_W] : ex_rs_data;
    w_exLoD  = w_isMd ? md_result[DATA_W-1:0] : ex_rs_data;
  end

  assign md_stall_req = w_isMd && !md_done && !flush && !rst;
  assign w_advance    = !stall_all && !md_stall_req;

  // Flush outranks stall_all: WB still retires, both latches are emptied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memWeHi <= 1'b0;
      r_memWeLo <= 1'b0;
      r_memHiD  <= '0;
      r_memLoD  <= '0;
      r_wbWeHi  <= 1'b0;
      r_wbWeLo  <= 1'b0;
      r_wbHiD   <= '0;
      r_wbLoD   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (flush || w_advance) begin
      if (r_wbWeHi) r_hi <= r_wbHiD;
      if (r_wbWeLo) r_lo <= r_wbLoD;
      if (flush) begin
        r_wbWeHi  <= 1'b0;
        r_wbWeLo  <= 1'b0;
        r_memWeHi <= 1'b0;
        r_memWeLo <= 1'b0;
      end else begin
        r_wbWeHi  <= r_memWeHi;
        r_wbWeLo  <= r_memWeLo;
        r_wbHiD   <= r_memHiD;
        r_wbLoD   <= r_memLoD;
        r_memWeHi <= w_exWeHi;
        r_memWeLo <= w_exWeLo;
        r_memHiD  <= w_exHiD;
        r_memLoD  <= w_exLoD;
      end
    end
  end

  // Youngest pending write wins, each half resolved on its own.
  always_comb begin
    w_fwdHi = r_hi;
    w_fwdLo = r_lo;
    if (FWD_EN) begin
      if (r_memWeHi)     w_fwdHi = r_memHiD;
      else if (r_wbWeHi) w_fwdHi = r_wbHiD;
      if (r_memWeLo)     w_fwdLo = r_memLoD;
      else if (r_wbWeLo) w_fwdLo = r_wbLoD;
    end
    ex_hilo_rdata = '0;
    if (ex_funct == FN_MFHI)      ex_hilo_rdata = w_fwdHi;
    else if (ex_funct == FN_MFLO) ex_hilo_rdata = w_fwdLo;
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit: forwarding, mult/div stall,
// flush, global stall and reset behaviour.
module tb_hilo_unit;

  logic        clk;
  logic        rst;
  logic        stall_all;
  logic        flush;
  logic [5:0]  ex_funct;
  logic [31:0] ex_rs_data;
  logic        md_done;
  logic [63:0] md_result;
  logic        md_stall_req;
  logic [31:0] ex_hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] MFHI = 6'h10;
  localparam logic [5:0] MTHI = 6'h11;
  localparam logic [5:0] MFLO = 6'h12;
  localparam logic [5:0] MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18;
  localparam logic [5:0] DIV  = 6'h1A;

  hilo_unit #(.DATA_W(32), .FWD_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .stall_all(stall_all),
    .flush(flush),
    .ex_funct(ex_funct),
    .ex_rs_data(ex_rs_data),
    .md_done(md_done),
    .md_result(md_result),
    .md_stall_req(md_stall_req),
    .ex_hilo_rdata(ex_hilo_rdata),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] fn, input logic [31:0] rs);
    ex_funct   = fn;
    ex_rs_data = rs;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    stall_all = 1'b0;
    flush = 1'b0;
    md_done = 1'b0;
    md_result = 64'h0;
    drive(MULT, 32'h0);
    tick();
    tick();
    check("rst_stall_comb", {31'b0, md_stall_req}, 32'h0);
    ex_funct = MFHI;
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_rdata", ex_hilo_rdata, 32'h0);
    rst = 1'b0;

    // MTHI then MFHI
    drive(MTHI, 32'hDEAD_BEEF);
    tick();
    drive(MFHI, 32'h0);
    #1;
    check("mthi_mem_fwd", ex_hilo_rdata, 32'hDEAD_BEEF);
    check("mthi_hi_early", hi, 32'h0);
    tick();
    check("mthi_wb_fwd", ex_hilo_rdata, 32'hDEAD_BEEF);
    check("mthi_hi_wb", hi, 32'h0);
    drive(NOP, 32'h0);
    tick();
    check("mthi_hi_commit", hi, 32'hDEAD_BEEF);
    check("mthi_lo_untouched", lo, 32'h0);

    // MULT with done delayed three cycles
    drive(MULT, 32'h0);
    md_result = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mult_stall_req", {31'b0, md_stall_req}, 32'h1);
      tick();
    end
    check("mult_hi_held", hi, 32'hDEAD_BEEF);
    md_done = 1'b1;
    #1;
    check("mult_done_no_stall", {31'b0, md_stall_req}, 32'h0);
    tick();
    md_done = 1'b0;
    drive(NOP, 32'h0);
    tick();
    check("mult_hi_pending", hi, 32'hDEAD_BEEF);
    tick();
    check("mult_hi", hi, 32'h1234_5678);
    check("mult_lo", lo, 32'h9ABC_DEF0);

    // Back-to-back MTLO: MEM beats WB
    drive(MTLO, 32'h1);
    tick();
    drive(MTLO, 32'h2);
    tick();
    drive(MFLO, 32'h0);
    #1;
    check("mtlo_mem_beats_wb", ex_hilo_rdata, 32'h2);
    tick();
    check("mtlo_first_commit", lo, 32'h1);
    check("mtlo_wb_fwd", ex_hilo_rdata, 32'h2);
    drive(NOP, 32'h0);
    tick();
    check("mtlo_final", lo, 32'h2);
    check("mtlo_hi_untouched", hi, 32'h1234_5678);

    // Flush with MTHI in MEM and MTLO in WB
    drive(MTLO, 32'h5);
    tick();
    drive(MTHI, 32'hAAAA);
    tick();
    drive(NOP, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(MFHI, 32'h0);
    #1;
    check("flush_lo_commit", lo, 32'h5);
    check("flush_mem_killed_fwd", ex_hilo_rdata, 32'h1234_5678);
    drive(NOP, 32'h0);
    tick();
    tick();
    check("flush_hi_kept", hi, 32'h1234_5678);

    // stall_all with MTHI in WB
    drive(MTHI, 32'h77);
    tick();
    drive(NOP, 32'h0);
    tick();
    stall_all = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("stall_hi_held", hi, 32'h1234_5678);
    ex_funct = MFHI;
    #1;
    check("stall_wb_fwd", ex_hilo_rdata, 32'h77);
    ex_funct = NOP;
    stall_all = 1'b0;
    tick();
    check("stall_hi_commit", hi, 32'h77);
    drive(MTHI, 32'h99);
    tick();
    drive(NOP, 32'h0);
    tick();
    check("stall_no_early", hi, 32'h77);
    tick();
    check("stall_next_commit", hi, 32'h99);

    // Reset during an outstanding DIV
    drive(MTLO, 32'h9);
    tick();
    drive(DIV, 32'h0);
    md_result = 64'hFFFF_0000_0000_FFFF;
    #1;
    check("div_stall_req", {31'b0, md_stall_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("div_rst_stall_drop", {31'b0, md_stall_req}, 32'h0);
    tick();
    rst = 1'b0;
    drive(MFLO, 32'h0);
    #1;
    check("div_rst_stall", {31'b0, md_stall_req}, 32'h0);
    check("div_rst_hi", hi, 32'h0);
    check("div_rst_lo", lo, 32'h0);
    check("div_rst_rdata", ex_hilo_rdata, 32'h0);
    drive(NOP, 32'h0);
    tick();
    tick();
    check("div_rst_discard", lo, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
